// File: rtl/imem_responder.sv
// Instruction-memory responder: single outstanding fetch, fixed wait-state latency, flushable.
// Optional `IMEM_BOUNDS_CHECK_EN flags misaligned/out-of-range fetches with rsp_err.
module imem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    input  logic                     flush,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data
);
    localparam int          AW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] rsp_data_q;
    logic        accept;
    logic        enter_resp;
    logic [31:0] rd_addr;
    logic [AW-1:0] rd_idx;

    logic [31:0] mem [DEPTH] = '{default: NOP};

    assign req_ready = (state_q == S_IDLE) && !flush;
    assign accept    = req_valid && req_ready;

    // With zero wait states the read happens on the accept edge itself, before addr_q is loaded.
    assign rd_addr = (state_q == S_IDLE) ? req_addr : addr_q;
    assign rd_idx  = rd_addr[AW+1:2];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (flush || rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef IMEM_BOUNDS_CHECK_EN
    logic addr_bad;
    logic rsp_err_q;

    assign addr_bad = (rd_addr[1:0] != 2'b00) || (rd_addr >= 32'(4 * DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= NOP;
            rsp_err_q  <= 1'b0;
        end else if (enter_resp) begin
            rsp_data_q <= addr_bad ? NOP : mem[rd_idx];
            rsp_err_q  <= addr_bad;
        end
    end

    assign rsp_err = rsp_valid && rsp_err_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr[31:AW+2], rd_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= NOP;
        end else if (enter_resp) begin
            rsp_data_q <= mem[rd_idx];
        end
    end

    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) addr_q <= req_addr;
        end
    end

    // NOTE: the memory array has no reset so it maps to RAM and survives rst_n.
    always_ff @(posedge clk) begin
        if (load_we) mem[load_addr] <= load_data;
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_valid ? rsp_data_q : NOP;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: main instance with 2 wait states, second with 0.
// Expectations follow `IMEM_BOUNDS_CHECK_EN when the bench is built with it.
module tb_imem_responder;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, flush, load_we;
    logic [31:0] req_addr, rsp_data, load_data;
    logic [7:0]  load_addr;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_flush, b_load_we;
    logic [31:0] b_req_addr, b_rsp_data, b_load_data;
    logic [7:0]  b_load_addr;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   b_deliv = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(256), .WAIT_STATES(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flush(flush), .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );

    imem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .flush(b_flush), .load_we(b_load_we), .load_addr(b_load_addr), .load_data(b_load_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        total_cnt++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every delivered response (handshake not overridden by flush) must match the queue head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready && !flush) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp_valid", rsp_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_err", rsp_err, e.err);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_rsp_valid && b_rsp_ready && !b_flush) b_deliv++;
    end

    task automatic load(input int idx, input logic [31:0] d);
        load_we = 1'b1; load_addr = 8'(idx); load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin tick(); n++; end
        if (sb.size() != 0) begin timeout("drain"); sb.delete(); end
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] d, input logic e);
        int n = 0;
        sb.push_back('{data: d, err: e});
        req_addr = addr; req_valid = 1'b1;
        while (!req_ready && n < 20) begin tick(); n++; end
        if (!req_ready) timeout("accept");
        tick();
        req_valid = 1'b0;
        drain();
    endtask

    task automatic wait_rsp_valid();
        int n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        if (!rsp_valid) timeout("rsp_valid");
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_addr = '0; rsp_ready = 1'b1; flush = 0;
        load_we = 0; load_addr = '0; load_data = '0;
        b_req_valid = 0; b_req_addr = '0; b_rsp_ready = 1'b1; b_flush = 0;
        b_load_we = 0; b_load_addr = '0; b_load_data = '0;
        #1;
        check("reset_req_ready", req_ready, 1'b1);
        #21;
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_data", rsp_data, NOP);
        check("reset_rsp_err", rsp_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // Unloaded word reads as NOP
        fetch(32'h24, NOP, 1'b0);

        // Fixed latency: accept edge, valid two cycles later, idle the cycle after
        load(3, 32'h0020_81B3);
        sb.push_back('{data: 32'h0020_81B3, err: 1'b0});
        req_addr = 32'h0C; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        @(negedge clk) check("lat_c1_valid", rsp_valid, 1'b0);
        @(negedge clk) check("lat_c2_valid", rsp_valid, 1'b0);
        @(negedge clk) check("lat_c3_valid", rsp_valid, 1'b1);
        @(negedge clk) check("lat_c4_valid", rsp_valid, 1'b0);
        check("lat_c4_ready", req_ready, 1'b1);
        tick();
        drain();

        // Flush during WAIT: no response, ready next cycle, next fetch works
        load(4, 32'h4020_8233);
        req_addr = 32'h0C; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk) check("flush_wait_ready", req_ready, 1'b1);
        check("flush_wait_valid", rsp_valid, 1'b0);
        repeat (4) tick();
        fetch(32'h10, 32'h4020_8233, 1'b0);

        // Flush in RESP wins over rsp_ready
        rsp_ready = 1'b0;
        req_addr = 32'h0C; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_rsp_valid();
        flush = 1'b1; rsp_ready = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk) check("flush_resp_valid", rsp_valid, 1'b0);
        check("flush_resp_ready", req_ready, 1'b1);
        tick();

        // Flush in IDLE blocks acceptance
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0C;
        @(negedge clk) check("flush_idle_ready", req_ready, 1'b0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk) check("flush_idle_no_accept", req_ready, 1'b1);
        tick();

        // Load collides with the read edge: old word first, then the new one
        load(5, 32'h0031_0293);
        sb.push_back('{data: 32'h0031_0293, err: 1'b0});
        req_addr = 32'h14; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        load_we = 1'b1; load_addr = 8'd5; load_data = 32'h0041_8313;
        tick();
        load_we = 1'b0;
        drain();
        fetch(32'h14, 32'h0041_8313, 1'b0);

        // Address range / alignment
        load(0, 32'h0010_0093);
`ifdef IMEM_BOUNDS_CHECK_EN
        fetch(32'h402, NOP, 1'b1);
        fetch(32'h400, NOP, 1'b1);
        fetch(32'h0D, NOP, 1'b1);
`else
        fetch(32'h400, 32'h0010_0093, 1'b0);
        fetch(32'h402, 32'h0010_0093, 1'b0);
        fetch(32'h0D, 32'h0020_81B3, 1'b0);
`endif

        // Asynchronous reset while in RESP: immediate reset outputs, no response afterwards
        rsp_ready = 1'b0;
        req_addr = 32'h0C; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_rsp_valid();
        #2 rst_n = 1'b0;
        #1;
        check("rst_resp_valid", rsp_valid, 1'b0);
        check("rst_resp_data", rsp_data, NOP);
        check("rst_resp_err", rsp_err, 1'b0);
        check("rst_resp_ready", req_ready, 1'b1);
        tick();
        rst_n = 1'b1; rsp_ready = 1'b1;
        repeat (5) tick();
        check("rst_no_rsp", rsp_valid, 1'b0);
        fetch(32'h0C, 32'h0020_81B3, 1'b0);

        // Zero-wait-state instance: response held stable while rsp_ready is low
        b_load_we = 1'b1; b_load_addr = 8'd7; b_load_data = 32'h00A0_0093;
        tick();
        b_load_we = 1'b0;
        b_rsp_ready = 1'b0;
        b_req_addr = 32'h1C; b_req_valid = 1'b1;
        tick();
        b_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ws0_hold_valid", b_rsp_valid, 1'b1);
            check("ws0_hold_data", b_rsp_data, 32'h00A0_0093);
            check("ws0_hold_ready", b_req_ready, 1'b0);
        end
        b_rsp_ready = 1'b1;
        tick();
        @(negedge clk) check("ws0_done_valid", b_rsp_valid, 1'b0);
        check("ws0_done_ready", b_req_ready, 1'b1);
        repeat (3) tick();
        check("ws0_deliveries", 32'(b_deliv), 32'd1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
